// File: rtl/c7bbiu_wr_arb_rr.sv
// c7bbiu write-path arbiter: grants one requester per AXI write transaction, drives AW then the W burst.
// Build option C7BBIU_WR_ARB_RR_EN: round-robin when defined, fixed priority (lowest index) otherwise.
module c7bbiu_wr_arb_rr #(
    parameter int              NREQ    = 2,
    parameter int              ADDR_W  = 32,
    parameter int              DATA_W  = 32,
    parameter int              ID_W    = 4,
    parameter logic [ID_W-1:0] ID_BASE = 4'h1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       axi_aw_ready,
    input  logic                       axi_w_ready,
    input  logic [NREQ-1:0]            req_aw_req,
    output logic [NREQ-1:0]            req_aw_ack,
    input  logic [NREQ-1:0]            req_w_req,
    output logic [NREQ-1:0]            req_w_ack,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*8-1:0]          req_len,
    input  logic [NREQ*3-1:0]          req_size,
    input  logic [NREQ*2-1:0]          req_burst,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    input  logic [NREQ*DATA_W/8-1:0]   req_wstrb,
    output logic                       arb_wr_aw_val,
    output logic [ID_W-1:0]            arb_wr_aw_id,
    output logic [ADDR_W-1:0]          arb_wr_aw_addr,
    output logic [7:0]                 arb_wr_aw_len,
    output logic [2:0]                 arb_wr_aw_size,
    output logic [1:0]                 arb_wr_aw_burst,
    output logic                       arb_wr_aw_lock,
    output logic [3:0]                 arb_wr_aw_cache,
    output logic [2:0]                 arb_wr_aw_prot,
    output logic                       arb_wr_w_val,
    output logic [ID_W-1:0]            arb_wr_w_id,
    output logic [DATA_W-1:0]          arb_wr_w_data,
    output logic [DATA_W/8-1:0]        arb_wr_w_strb,
    output logic                       arb_wr_w_last,
    output logic [NREQ-1:0]            arb_wr_grant
);

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2
    } state_t;

    state_t            state_r;
    logic [NREQ-1:0]   grant_r;
    logic [PTR_W-1:0]  gidx_r;
    logic [7:0]        len_r;
    logic [7:0]        beat_cnt_r;

    logic [PTR_W-1:0]  start_s;
    logic [PTR_W-1:0]  win_idx_s;
    logic              win_found_s;
    logic              aw_val_s;
    logic              aw_hs_s;
    logic              w_val_s;
    logic              w_hs_s;
    logic              w_last_s;
    logic [ID_W-1:0]   id_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [2:0]        sel_size_s;
    logic [1:0]        sel_burst_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [STRB_W-1:0] sel_strb_s;

`ifdef C7BBIU_WR_ARB_RR_EN
    logic [PTR_W-1:0]  rr_ptr_r;
    assign start_s = rr_ptr_r;
`else
    assign start_s = '0;
`endif

    // Search from start_s with wrap-around; the first asserted AW request wins.
    always_comb begin
        int  cand;
        logic hit;
        cand        = 0;
        hit         = 1'b0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand        = ((int'(start_s) + k) >= NREQ) ? (int'(start_s) + k - NREQ) : (int'(start_s) + k);
            hit         = !win_found_s && req_aw_req[cand];
            win_idx_s   = hit ? PTR_W'(cand) : win_idx_s;
            win_found_s = win_found_s | hit;
        end
    end

    assign aw_val_s = (state_r == S_AW);
    assign aw_hs_s  = aw_val_s & axi_aw_ready;
    assign w_val_s  = (state_r == S_W) & req_w_req[gidx_r];
    assign w_hs_s   = w_val_s & axi_w_ready;
    assign w_last_s = (beat_cnt_r == len_r);
    assign id_s     = ID_BASE + ID_W'(gidx_r);

    assign sel_addr_s  = req_addr[int'(gidx_r)*ADDR_W +: ADDR_W];
    assign sel_size_s  = req_size[int'(gidx_r)*3 +: 3];
    assign sel_burst_s = req_burst[int'(gidx_r)*2 +: 2];
    assign sel_data_s  = req_wdata[int'(gidx_r)*DATA_W +: DATA_W];
    assign sel_strb_s  = req_wstrb[int'(gidx_r)*STRB_W +: STRB_W];

    // Payloads are forced to zero whenever their channel is not valid.
    assign arb_wr_aw_val   = aw_val_s;
    assign arb_wr_aw_id    = aw_val_s ? id_s : '0;
    assign arb_wr_aw_addr  = aw_val_s ? sel_addr_s : '0;
    assign arb_wr_aw_len   = aw_val_s ? len_r : 8'd0;
    assign arb_wr_aw_size  = aw_val_s ? sel_size_s : 3'd0;
    assign arb_wr_aw_burst = aw_val_s ? sel_burst_s : 2'd0;
    assign arb_wr_aw_lock  = 1'b0;
    assign arb_wr_aw_cache = 4'b0000;
    assign arb_wr_aw_prot  = 3'b000;

    assign arb_wr_w_val  = w_val_s;
    assign arb_wr_w_id   = w_val_s ? id_s : '0;
    assign arb_wr_w_data = w_val_s ? sel_data_s : '0;
    assign arb_wr_w_strb = w_val_s ? sel_strb_s : '0;
    assign arb_wr_w_last = w_val_s & w_last_s;

    assign req_aw_ack   = aw_hs_s ? grant_r : '0;
    assign req_w_ack    = w_hs_s ? grant_r : '0;
    assign arb_wr_grant = grant_r;

    // Transaction FSM: arbitrate in IDLE, hold the grant through AW and every W beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            grant_r    <= '0;
            gidx_r     <= '0;
            len_r      <= 8'd0;
            beat_cnt_r <= 8'd0;
`ifdef C7BBIU_WR_ARB_RR_EN
            rr_ptr_r   <= '0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (win_found_s) begin
                        state_r <= S_AW;
                        grant_r <= NREQ'(1) << win_idx_s;
                        gidx_r  <= win_idx_s;
                        len_r   <= req_len[int'(win_idx_s)*8 +: 8];
                    end
                end
                S_AW: begin
                    if (aw_hs_s) begin
                        state_r    <= S_W;
                        beat_cnt_r <= 8'd0;
`ifdef C7BBIU_WR_ARB_RR_EN
                        rr_ptr_r   <= (gidx_r == PTR_W'(NREQ - 1)) ? '0 : gidx_r + PTR_W'(1);
`endif
                    end
                end
                S_W: begin
                    if (w_hs_s) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                        if (w_last_s) begin
                            state_r <= S_IDLE;
                            grant_r <= '0;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

endmodule
